// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: op encodings, FSM states,
// datapath and counter widths, and the flag consistency check.
package alu_op_sequencer_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Only ADD/SUB may legitimately raise carry or overflow.
    function automatic logic flag_mismatch(logic [2:0] op, logic res_is_zero,
                                           logic carry, logic ovf, logic zero);
        return (zero != res_is_zero) || ((carry || ovf) && (op >= 3'(ALU_SLT)));
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response bundle between a front end, the sequencer
// and the combinational ALU.
interface alu_op_sequencer_if #(parameter int WIDTH = 32);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carryout;
    logic             alu_overflow;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carryout;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic [2:0]       rsp_op;
    logic             flag_err;

    // Front end plus ALU side.
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output alu_out, alu_carryout, alu_overflow, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow,
        input  rsp_zero, rsp_op, flag_err, alu_a, alu_b, alu_control
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  alu_out, alu_carryout, alu_overflow, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_overflow,
        output rsp_zero, rsp_op, flag_err, alu_a, alu_b, alu_control
    );

endinterface

// File: rtl/alu_op_sequencer_settle_counter.sv
// Down-counter timing how long the ALU inputs are held before the result is captured.
module settle_counter
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the unclocked ALU: registers a request onto the ALU inputs,
// waits SETTLE_CYCLES, captures result/flags and returns them as a response.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH         = alu_op_sequencer_pkg::WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state;
    logic             accept;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt;
    logic             res_is_zero;

    // In RESPOND a new request can only enter on the edge that retires the response.
    assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RESPOND) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign res_is_zero   = (bus.alu_out == {WIDTH{1'b0}});

    settle_counter u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (SETTLE_LOAD),
        .dec      (state == ST_SETTLE),
        .done     (cnt_done),
        .cnt      (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_control  <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_carryout <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_op       <= '0;
            bus.flag_err     <= 1'b0;
        end else begin
            // ALU inputs move only here so the settle window always sees stable values.
            if (accept) begin
                bus.alu_a       <= bus.req_a;
                bus.alu_b       <= bus.req_b;
                bus.alu_control <= bus.req_op;
            end

            unique case (state)
                ST_IDLE: begin
                    if (accept)
                        state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_done) begin
                        bus.rsp_valid    <= 1'b1;
                        bus.rsp_result   <= bus.alu_out;
                        bus.rsp_carryout <= bus.alu_carryout;
                        bus.rsp_overflow <= bus.alu_overflow;
                        bus.rsp_zero     <= bus.alu_zero;
                        bus.rsp_op       <= bus.alu_control;
                        if (flag_mismatch(bus.alu_control, res_is_zero, bus.alu_carryout,
                                          bus.alu_overflow, bus.alu_zero))
                            bus.flag_err <= 1'b1;
                        state <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= accept ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU that can be forced
// to report an inconsistent zero flag.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    logic stub_bad;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        c, v, z;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    alu_op_sequencer_if #(.WIDTH(32)) bus();

    alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; carry on SUB means "no borrow".
    logic [32:0] sum;
    logic [31:0] r;
    logic        ovf;
    always_comb begin
        sum = '0;
        r   = '0;
        ovf = 1'b0;
        case (bus.alu_control)
            3'd0: begin
                sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                r   = sum[31:0];
                ovf = (bus.alu_a[31] == bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'd1: begin
                sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                r   = sum[31:0];
                ovf = (bus.alu_a[31] != bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'd2: r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            3'd3: r = bus.alu_a ^ bus.alu_b;
            3'd4: r = bus.alu_a & bus.alu_b;
            3'd5: r = ~(bus.alu_a & bus.alu_b);
            3'd6: r = ~(bus.alu_a | bus.alu_b);
            default: r = bus.alu_a | bus.alu_b;
        endcase
    end
    assign bus.alu_out      = r;
    assign bus.alu_carryout = sum[32];
    assign bus.alu_overflow = ovf;
    assign bus.alu_zero     = (r == 32'd0) || stub_bad;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: latency on each new response, payload on each handshake.
    logic last_v = 1'b0, last_hs = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            last_v  = 1'b0;
            last_hs = 1'b0;
        end else begin
            if (bus.rsp_valid && (!last_v || last_hs)) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_latency", cyc - exp_q[0].acc, S);
            end
            if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_result", bus.rsp_result, e.res);
                check("rsp_op_flags", {bus.rsp_op, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero},
                      {e.op, e.c, e.v, e.z});
            end
            last_v  = bus.rsp_valid;
            last_hs = bus.rsp_valid && bus.rsp_ready;
        end
    end

    // ALU inputs may only change on an accept edge (or reset).
    logic [66:0] alu_prev = '0;
    logic acc_prev = 1'b0, rst_prev = 1'b1;
    always @(negedge clk) begin
        if ({bus.alu_a, bus.alu_b, bus.alu_control} != alu_prev && !rst_prev)
            check("alu_in_change_on_accept", acc_prev, 1);
        alu_prev = {bus.alu_a, bus.alu_b, bus.alu_control};
        acc_prev = bus.req_valid && bus.req_ready && !reset;
        rst_prev = reset;
    end

    task automatic send(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] res, logic c, logic v, logic z);
        exp_t e;
        bit ok;
        ok = 1'b0;
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) check("req_accept_timeout", 0, 1);
        else begin
            e.op = op; e.res = res; e.c = c; e.v = v; e.z = z; e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.rsp_valid) done = 1'b1;
        end
        if (!done) begin
            check("drain_timeout", 0, 1);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        bit got;
        reset = 1'b1; stub_bad = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_rsp", {bus.rsp_valid, bus.rsp_op, bus.rsp_carryout, bus.rsp_overflow,
                            bus.rsp_zero, bus.flag_err}, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        check("reset_alu_in", {bus.alu_a | bus.alu_b, bus.alu_control}, 0);
        @(posedge clk); #1;

        // Single ADD, then data must hold after the handshake.
        bus.rsp_ready = 1'b1;
        send(3'd0, 32'h5, 32'h3, 32'h8, 0, 0, 0);
        bus.req_valid = 1'b0;
        drain();
        check("rsp_hold_after_hs", bus.rsp_result, 32'h8);
        check("rsp_valid_drop", bus.rsp_valid, 0);

        send(3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, 0);
        bus.req_valid = 1'b0; drain();
        send(3'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0);
        bus.req_valid = 1'b0; drain();
        send(3'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 0, 0, 1);
        bus.req_valid = 1'b0; drain();
        check("flag_err_clean", bus.flag_err, 0);

        // Back-to-back with req_valid and rsp_ready held high.
        send(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0);
        send(3'd7, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 0, 0, 0);
        send(3'd6, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        send(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, 1);
        bus.req_valid = 1'b0;
        drain();

        // Response stalled for 5 cycles.
        bus.rsp_ready = 1'b0;
        send(3'd7, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0);
        bus.req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check("stall_rsp_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_rsp_stable", bus.rsp_result, 32'h1234_5678);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        drain();

        // Reset while settling discards the operation.
        send(3'd0, 32'h7, 32'h7, 32'hE, 0, 0, 0);
        bus.req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < S + 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        check("idle_after_reset", bus.req_ready, 1);
        @(posedge clk); #1;

        // Inconsistent zero flag makes flag_err stick until reset.
        stub_bad = 1'b1;
        send(3'd0, 32'h1, 32'h1, 32'h2, 0, 0, 1);
        bus.req_valid = 1'b0; drain();
        stub_bad = 1'b0;
        check("flag_err_set", bus.flag_err, 1);
        send(3'd3, 32'h1, 32'h2, 32'h3, 0, 0, 0);
        bus.req_valid = 1'b0; drain();
        check("flag_err_sticky", bus.flag_err, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("flag_err_reset", bus.flag_err, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
